// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master
//  Brief    : APB requester. Turns a valid/ready command into an APB
//             SETUP/ACCESS transfer, holds the bus through slave wait states,
//             aborts after a programmable number of unready ACCESS cycles and
//             returns a one-cycle response strobe with read data and status.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              pclk,
  input  logic              preset_n,
  // command side
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // response side
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  // APB side
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              psvlerr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  // Timeout fires on the ACCESS edge where the counter has already seen
  // TIMEOUT-1 unready cycles, giving exactly TIMEOUT ACCESS cycles in total.
  localparam bit         C_TO_EN   = (TIMEOUT != 0);
  localparam logic [7:0] C_TO_LAST = 8'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e              state_q;
  logic [7:0]          wait_q;
  logic [7:0]          wait_d;
  logic                psel_q;
  logic                penable_q;
  logic                pwrite_q;
  logic [ADDR_W-1:0]   paddr_q;
  logic [DATA_W-1:0]   pwdata_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;
  logic                rsp_timeout_q;
  logic                timeout_hit;

  // Next wait count and the abort condition, both purely from registered state.
  always_comb begin
    wait_d      = wait_q + 8'd1;
    timeout_hit = C_TO_EN && (wait_q == C_TO_LAST);
  end

  // Transfer sequencer: IDLE -> SETUP -> ACCESS (wait states) -> IDLE with response.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q       <= ST_IDLE;
      wait_q        <= 8'd0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      // Response strobe is a single-cycle pulse unless re-armed below.
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            paddr_q   <= cmd_addr;
            pwrite_q  <= cmd_write;
            pwdata_q  <= cmd_wdata;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          wait_q    <= 8'd0;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // A ready slave wins over a timeout landing on the same edge.
          if (pready) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= psvlerr;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= pwrite_q ? '0 : prdata;
            state_q       <= ST_IDLE;
          end else if (timeout_hit) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
            state_q       <= ST_IDLE;
          end else begin
            wait_q <= wait_d;
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_master
//  Brief    : Scoreboard bench for apb_master with a behavioural APB slave.
//             Expected responses and bus shapes are queued at command accept
//             and popped by independent bus and response monitors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master;

  localparam int TMO = 4;

  logic       pclk = 1'b0;
  logic       preset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       rsp_timeout;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata = 8'h00;
  logic       pready = 1'b0;
  logic       psvlerr = 1'b0;

  apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .psvlerr(psvlerr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [7:0] addr;
    logic       wr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
    logic       to;
    int         acc;
  } exp_t;

  exp_t       rsp_q[$];
  exp_t       bus_q[$];
  int         slv_q[$];
  logic [7:0] model_mem [8];
  logic [7:0] smem [8];
  int         checks = 0;
  int         errors = 0;
  bit         b2b_mode = 1'b0;

  function automatic bit is_onehot(input logic [7:0] a);
    return (a != 8'h00) && ((a & (a - 8'd1)) == 8'h00);
  endfunction

  function automatic int bit_idx(input logic [7:0] a);
    for (int i = 0; i < 8; i++) if (a[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outcome of a transfer from address decode, stored
  // register values, slave wait count and the timeout limit.
  function automatic exp_t predict(input logic wr, input logic [7:0] a,
                                   input logic [7:0] d, input int w);
    exp_t e;
    e.addr = a; e.wr = wr; e.wdata = d;
    if (w >= TMO) begin
      e.rdata = 8'h00; e.err = 1'b1; e.to = 1'b1; e.acc = TMO;
    end else begin
      e.err = !is_onehot(a);
      e.to  = 1'b0;
      e.acc = w + 1;
      if (wr) e.rdata = 8'h00;
      else    e.rdata = is_onehot(a) ? model_mem[bit_idx(a)] : 8'hEE;
      if (wr && is_onehot(a)) model_mem[bit_idx(a)] = d;
    end
    return e;
  endfunction

  task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d, input int w);
    exp_t e;
    int   g;
    g = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && g < 100) begin
      @(negedge pclk);
      g++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    if (cmd_ready) begin
      e = predict(wr, a, d, w);
      rsp_q.push_back(e);
      bus_q.push_back(e);
      slv_q.push_back(w);
      @(negedge pclk);
    end
  endtask

  task automatic idle_drain();
    int g;
    g = 0;
    cmd_valid = 1'b0;
    while (rsp_q.size() != 0 && g < 200) begin
      @(negedge pclk);
      g++;
    end
    chk("drain_pending", rsp_q.size(), 0);
    repeat (2) @(negedge pclk);
  endtask

  // Behavioural APB slave: 8 registers selected one-hot, non-one-hot is an error.
  int s_acnt = 0;
  initial begin : slave
    forever begin
      @(negedge pclk);
      if (!preset_n) begin
        s_acnt = 0;
      end else if (psel && penable) begin
        pready  = (slv_q.size() != 0) && (s_acnt == slv_q[0]);
        psvlerr = !is_onehot(paddr);
        prdata  = is_onehot(paddr) ? smem[bit_idx(paddr)] : 8'hEE;
        if (pready && pwrite && is_onehot(paddr)) smem[bit_idx(paddr)] = pwdata;
        s_acnt++;
      end else begin
        if (s_acnt != 0 && slv_q.size() != 0) void'(slv_q.pop_front());
        s_acnt  = 0;
        pready  = 1'($urandom);
        psvlerr = 1'($urandom);
        prdata  = 8'($urandom);
      end
    end
  end

  // Bus monitor: transfer shape, held address/data, inter-transfer gap.
  int b_acc = 0, b_setup = 0, b_gap = 0;
  bit b_prev_psel = 1'b0, b_end_b2b = 1'b0;
  initial begin : bus_mon
    exp_t e;
    forever begin
      @(negedge pclk);
      if (!preset_n) begin
        b_acc = 0; b_setup = 0; b_gap = 0; b_prev_psel = 1'b0; b_end_b2b = 1'b0;
      end else begin
        if (psel && !b_prev_psel) begin
          if (b_end_b2b && b2b_mode) chk("b2b_gap", b_gap, 1);
          b_end_b2b = 1'b0;
        end
        if (psel && !penable) begin
          b_setup++;
          chk("bus_expected", bus_q.size() != 0, 1);
          if (bus_q.size() != 0) chk("setup_paddr", paddr, bus_q[0].addr);
        end else if (psel && penable) begin
          b_acc++;
          if (bus_q.size() != 0) begin
            chk("acc_paddr", paddr, bus_q[0].addr);
            chk("acc_pwrite", pwrite, bus_q[0].wr);
            if (bus_q[0].wr) chk("acc_pwdata", pwdata, bus_q[0].wdata);
          end
        end else begin
          chk("idle_penable", penable, 0);
          if (b_acc != 0 || b_setup != 0) begin
            chk("bus_pop", bus_q.size() != 0, 1);
            if (bus_q.size() != 0) begin
              e = bus_q.pop_front();
              chk("setup_cycles", b_setup, 1);
              chk("access_cycles", b_acc, e.acc);
            end
            b_end_b2b = b2b_mode;
            b_gap = 0;
          end
          b_gap++;
          b_acc = 0; b_setup = 0;
        end
        b_prev_psel = psel;
      end
    end
  end

  // Response monitor: pops the scoreboard on each strobe, checks hold between strobes.
  initial begin : rsp_mon
    exp_t e, last;
    bit   prev_v, have_last;
    prev_v = 1'b0; have_last = 1'b0;
    forever begin
      @(negedge pclk);
      if (!preset_n) begin
        prev_v = 1'b0; have_last = 1'b0;
      end else begin
        if (rsp_valid) begin
          chk("rsp_single_pulse", prev_v, 0);
          chk("rsp_expected", rsp_q.size() != 0, 1);
          if (rsp_q.size() != 0) begin
            e = rsp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_timeout", rsp_timeout, e.to);
            last = e; have_last = 1'b1;
          end
        end else if (have_last) begin
          chk("hold_rdata", rsp_rdata, last.rdata);
          chk("hold_err", rsp_err, last.err);
          chk("hold_timeout", rsp_timeout, last.to);
        end
        prev_v = rsp_valid;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] alist [11];
    logic [7:0] a;
    alist = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h03, 8'h00, 8'hC0};
    for (int i = 0; i < 8; i++) begin
      model_mem[i] = 8'(i * 17);
      smem[i]      = 8'(i * 17);
    end
    repeat (3) @(negedge pclk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    preset_n = 1'b1;
    @(negedge pclk);

    // zero-wait write, then waited read-back
    issue(1'b1, 8'h04, 8'hA5, 0); idle_drain();
    issue(1'b0, 8'h04, 8'h00, 3); idle_drain();
    // slave error, then clean read
    issue(1'b1, 8'h03, 8'h5A, 0); idle_drain();
    issue(1'b0, 8'h01, 8'h00, 0); idle_drain();
    // timeout, ready on the last allowed cycle, timeout on a write
    issue(1'b0, 8'h02, 8'h00, 9); idle_drain();
    issue(1'b1, 8'h08, 8'h3C, TMO - 1); idle_drain();
    issue(1'b0, 8'h08, 8'h00, TMO - 1); idle_drain();
    issue(1'b1, 8'h10, 8'h77, TMO); idle_drain();
    issue(1'b0, 8'h10, 8'h00, 0); idle_drain();

    // back-to-back with cmd_valid held high
    b2b_mode = 1'b1;
    issue(1'b1, 8'h20, 8'h11, 0);
    issue(1'b1, 8'h40, 8'h22, 0);
    issue(1'b0, 8'h20, 8'h00, 0);
    idle_drain();
    b2b_mode = 1'b0;

    // asynchronous reset in the middle of ACCESS
    issue(1'b0, 8'h02, 8'h00, 2);
    cmd_valid = 1'b0;
    @(posedge pclk);
    #2 preset_n = 1'b0;
    #1;
    chk("mid_rst_psel", psel, 0);
    chk("mid_rst_penable", penable, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    rsp_q.delete(); bus_q.delete(); slv_q.delete();
    @(negedge pclk);
    #2 preset_n = 1'b1;
    repeat (6) @(negedge pclk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_rsp_rdata", rsp_rdata, 0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      a = alist[$urandom_range(0, 10)];
      issue(1'($urandom), a, 8'($urandom), int'($urandom_range(0, 6)));
      if ($urandom_range(0, 3) == 0) idle_drain();
    end
    idle_drain();
    chk("final_bus_q", bus_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
